// File: rtl/filter_pkg.sv
// Shared filter constants and the filter_aud_in handshake transfer condition.
// Used by both the audio transmit side and filter_stm.
`ifndef FILTER_XFER
`define FILTER_XFER(rts, rtr) ((rts) && (rtr))
`endif

package filter_pkg;

    localparam int unsigned AUD_W = 32;
    localparam int unsigned ACC_W = 40;

endpackage

// File: rtl/filter_aud_tx_if.sv
// filter_aud_in ready-to-send / ready-to-receive handshake bundle.
interface filter_aud_tx_if
    import filter_pkg::*;
#(
    parameter int unsigned DATA_W = AUD_W
);

    logic [DATA_W-1:0] filter_aud_in;
    logic              filter_aud_in_rts;
    logic              filter_aud_in_rtr;

    modport master (
        output filter_aud_in,
        output filter_aud_in_rts,
        input  filter_aud_in_rtr
    );

    modport slave (
        input  filter_aud_in,
        input  filter_aud_in_rts,
        output filter_aud_in_rtr
    );

endinterface

// File: rtl/aud_fifo_sync.sv
// Small synchronous sample FIFO with an explicit level counter and a look-ahead
// view of the head entry as it will be after the current cycle's push/pop.
module aud_fifo_sync #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic              push_ok_o,
    output logic              full_o,
    output logic [LVL_W-1:0]  level_o,
    output logic [LVL_W-1:0]  level_nxt_o,
    output logic [DATA_W-1:0] head_nxt_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [LVL_W-1:0]  lvl_after_pop;
    logic              pop_ok;
    logic              push_ok;
    logic              full;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign pop_ok  = pop_i && (level_q != '0);
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push_ok = push_i && (!full || pop_ok);

    always_comb begin
        rd_ptr_d      = rd_ptr_q + PTR_W'(pop_ok);
        wr_ptr_d      = wr_ptr_q + PTR_W'(push_ok);
        level_d       = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
        lvl_after_pop = level_q - LVL_W'(pop_ok);
        // Bypass: the incoming sample becomes head when nothing else is left.
        if (push_ok && (lvl_after_pop == '0)) begin
            head_nxt_o = wdata_i;
        end else begin
            head_nxt_o = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign push_ok_o   = push_ok;
    assign full_o      = full;
    assign level_o     = level_q;
    assign level_nxt_o = level_d;

endmodule

// File: rtl/filter_aud_tx.sv
// Audio transmit side of the filter input handshake: buffers strobed samples and
// presents them with registered rts/data, counting deliveries and flagging drops.
module filter_aud_tx
    import filter_pkg::*;
#(
    parameter int unsigned DATA_W = AUD_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    aud_in_vld_i,
    input  logic [DATA_W-1:0]       aud_in_i,
    filter_aud_tx_if.master         filt_if,
    output logic [LVL_W-1:0]        fifo_level_o,
    input  logic                    ovf_clr_i,
    output logic                    ovf_sticky_o,
    output logic [CNT_W-1:0]        tx_count_o
);

    logic              rts_q, rts_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              xfer;
    logic              drop;
    logic              push_ok;
    logic              full;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  level_nxt;
    logic [DATA_W-1:0] head_nxt;

    // rts_q is registered, so the transfer never feeds rtr back into rts.
    assign xfer = `FILTER_XFER(rts_q, filt_if.filter_aud_in_rtr);
    assign drop = aud_in_vld_i && full && !xfer;

    aud_fifo_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (aud_in_vld_i),
        .wdata_i     (aud_in_i),
        .pop_i       (xfer),
        .push_ok_o   (push_ok),
        .full_o      (full),
        .level_o     (level),
        .level_nxt_o (level_nxt),
        .head_nxt_o  (head_nxt)
    );

    always_comb begin
        rts_d  = (level_nxt != '0);
        data_d = data_q;
        if (level_nxt != '0) begin
            data_d = head_nxt;
        end
        ovf_d = ovf_q;
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(xfer);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rts_q  <= 1'b0;
            data_q <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            rts_q  <= rts_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_if.filter_aud_in_rts = rts_q;
    assign filt_if.filter_aud_in     = data_q;
    assign fifo_level_o              = level;
    assign ovf_sticky_o              = ovf_q;
    assign tx_count_o                = cnt_q;

    logic unused_push_ok;
    assign unused_push_ok = push_ok;

endmodule

// File: tb/tb_filter_aud_tx.sv
// Bench for filter_aud_tx: directed vector table, random back-pressure stream
// against a queue model, and an asynchronous mid-cycle reset sequence.
module tb_filter_aud_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [31:0] din = '0;
    logic        clr = 1'b0;
    logic [2:0]  level;
    logic        ovf;
    logic [15:0] cnt;

    int total = 0;
    int bad   = 0;

    filter_aud_tx_if #(.DATA_W(32)) fif ();

    filter_aud_tx #(
        .DATA_W (32),
        .DEPTH  (4),
        .CNT_W  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .aud_in_vld_i (vld),
        .aud_in_i     (din),
        .filt_if      (fif),
        .fifo_level_o (level),
        .ovf_clr_i    (clr),
        .ovf_sticky_o (ovf),
        .tx_count_o   (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] din;
        logic        rtr;
        logic        clr;
        logic        rts;
        logic [31:0] dout;
        int unsigned lvl;
        logic        ovf;
        int unsigned cnt;
    } vec_t;

    vec_t tbl[$];

    logic [31:0] q_m[$];
    logic        ovf_m;
    logic [15:0] cnt_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic v, input int d, input logic r, input logic c,
                       input logic ers, input int ed, input int el, input logic eo,
                       input int ec);
        vec_t t;
        t.vld = v; t.din = d; t.rtr = r; t.clr = c;
        t.rts = ers; t.dout = d == 0 ? 32'(ed) : 32'(ed); t.lvl = el; t.ovf = eo; t.cnt = ec;
        tbl.push_back(t);
    endtask

    // One cycle against the queue model; outputs checked 1 time unit after the edge.
    task automatic model_cycle(input logic v, input logic [31:0] d, input logic r,
                               input logic c);
        logic pop_m, push_m, full_m;
        full_m = (q_m.size() == 4);
        pop_m  = (q_m.size() != 0) && r;
        push_m = v && (!full_m || pop_m);
        vld = v; din = d; fif.filter_aud_in_rtr = r; clr = c;
        @(posedge clk);
        #1;
        if (pop_m) void'(q_m.pop_front());
        if (push_m) q_m.push_back(d);
        if (pop_m) cnt_m = cnt_m + 16'd1;
        if (c) ovf_m = 1'b0;
        if (v && full_m && !pop_m) ovf_m = 1'b1;
        chk("rnd rts", 32'(fif.filter_aud_in_rts), 32'(q_m.size() != 0));
        chk("rnd level", 32'(level), 32'(q_m.size()));
        chk("rnd count", 32'(cnt), 32'(cnt_m));
        chk("rnd ovf", 32'(ovf), 32'(ovf_m));
        if (q_m.size() != 0) chk("rnd data", fif.filter_aud_in, q_m[0]);
    endtask

    initial begin
        fif.filter_aud_in_rtr = 1'b0;
        #1;
        chk("reset rts", 32'(fif.filter_aud_in_rts), 32'd0);
        chk("reset data", fif.filter_aud_in, 32'd0);
        chk("reset level", 32'(level), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        chk("reset count", 32'(cnt), 32'd0);
        #11 rst = 1'b0;

        //  vld din rtr clr | rts dout lvl ovf cnt
        add(1, 7,  1, 0,  1, 7,  1, 0, 0);
        add(0, 0,  1, 0,  0, 7,  0, 0, 1);
        add(1, 13, 1, 0,  1, 13, 1, 0, 1);
        add(1, 3,  1, 0,  1, 3,  1, 0, 2);
        add(1, 5,  1, 0,  1, 5,  1, 0, 3);
        add(1, 8,  1, 0,  1, 8,  1, 0, 4);
        add(1, 18, 1, 0,  1, 18, 1, 0, 5);
        add(0, 0,  1, 0,  0, 18, 0, 0, 6);
        add(1, 21, 0, 0,  1, 21, 1, 0, 6);
        add(1, 22, 0, 0,  1, 21, 2, 0, 6);
        add(1, 23, 0, 0,  1, 21, 3, 0, 6);
        add(1, 24, 0, 0,  1, 21, 4, 0, 6);
        add(1, 25, 0, 0,  1, 21, 4, 1, 6);
        add(0, 0,  1, 0,  1, 22, 3, 1, 7);
        add(0, 0,  1, 0,  1, 23, 2, 1, 8);
        add(0, 0,  1, 0,  1, 24, 1, 1, 9);
        add(0, 0,  1, 0,  0, 24, 0, 1, 10);
        add(0, 0,  0, 1,  0, 24, 0, 0, 10);
        add(1, 31, 0, 0,  1, 31, 1, 0, 10);
        add(1, 32, 0, 0,  1, 31, 2, 0, 10);
        add(1, 33, 0, 0,  1, 31, 3, 0, 10);
        add(1, 34, 0, 0,  1, 31, 4, 0, 10);
        add(1, 35, 1, 0,  1, 32, 4, 0, 11);
        add(1, 36, 0, 1,  1, 32, 4, 1, 11);
        add(0, 0,  1, 0,  1, 33, 3, 1, 12);
        add(0, 0,  1, 0,  1, 34, 2, 1, 13);
        add(0, 0,  1, 0,  1, 35, 1, 1, 14);
        add(0, 0,  1, 0,  0, 35, 0, 1, 15);
        add(1, 40, 1, 0,  1, 40, 1, 1, 15);
        add(0, 0,  0, 0,  1, 40, 1, 1, 15);
        add(0, 0,  1, 0,  0, 40, 0, 1, 16);
        add(0, 0,  0, 1,  0, 40, 0, 0, 16);

        for (int i = 0; i < tbl.size(); i++) begin
            vld = tbl[i].vld; din = tbl[i].din;
            fif.filter_aud_in_rtr = tbl[i].rtr; clr = tbl[i].clr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d rts", i), 32'(fif.filter_aud_in_rts), 32'(tbl[i].rts));
            chk($sformatf("vec%0d data", i), fif.filter_aud_in, tbl[i].dout);
            chk($sformatf("vec%0d level", i), 32'(level), tbl[i].lvl);
            chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(tbl[i].ovf));
            chk($sformatf("vec%0d count", i), 32'(cnt), tbl[i].cnt);
        end

        // Random back-pressure stream.
        cnt_m = 16'd16;
        ovf_m = 1'b0;
        for (int i = 0; i < 1250; i++) begin
            model_cycle($urandom_range(0, 9) < 8, $urandom, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 8; i++) model_cycle(1'b0, 32'd0, 1'b1, 1'b0);
        model_cycle(1'b0, 32'd0, 1'b0, 1'b1);

        // Build level 3 with ovf set, then reset asynchronously mid-cycle.
        for (int i = 0; i < 5; i++) model_cycle(1'b1, 32'(51 + i), 1'b0, 1'b0);
        model_cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("pre-reset level", 32'(level), 32'd3);
        fif.filter_aud_in_rtr = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async rts", 32'(fif.filter_aud_in_rts), 32'd0);
        chk("async level", 32'(level), 32'd0);
        chk("async count", 32'(cnt), 32'd0);
        chk("async ovf", 32'(ovf), 32'd0);
        chk("async data", fif.filter_aud_in, 32'd0);
        #3 rst = 1'b0;
        q_m.delete();
        cnt_m = 16'd0;
        ovf_m = 1'b0;
        for (int i = 0; i < 4; i++) begin
            model_cycle(1'b0, 32'd0, 1'b1, 1'b0);
            chk("post-reset data", fif.filter_aud_in, 32'd0);
        end
        model_cycle(1'b1, 32'd77, 1'b1, 1'b0);
        model_cycle(1'b0, 32'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
